// File: rtl/btn_cond_if.sv
// Counter command bundle from btn_cond: one-cycle load/preset/clear pulses plus load data.
interface btn_cond_if;
  logic       load_pulse;
  logic       pre_pulse;
  logic       clr_pulse;
  logic [3:0] data_out;

  modport master (
    output load_pulse,
    output pre_pulse,
    output clr_pulse,
    output data_out
  );

  modport slave (
    input load_pulse,
    input pre_pulse,
    input clr_pulse,
    input data_out
  );
endinterface

// File: rtl/btn_cond.sv
// Button conditioner: synchronise, debounce and pulse load/preset/clear, register switch value.
// Optional BTN_COND_AUTO_REPEAT_EN adds periodic load repeats while the load button is held.
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       btn_load,
  input  logic       btn_pre,
  input  logic       btn_clr,
  input  logic [3:0] sw,
  btn_cond_if.master cmd
);

  typedef enum logic [1:0] {StReleased, StPressWait, StHeld, StReleaseWait} state_e;

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  // Bits [2:0] are load/pre/clr buttons, [6:3] the switch value.
  logic [6:0] sync1_q, sync2_q;
  logic [2:0] btn_s;
  logic [3:0] sw_s;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw, btn_clr, btn_pre, btn_load};
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q[2:0];
  assign sw_s  = sync2_q[6:3];

  state_e     state_q [3];
  state_e     state_d [3];
  logic [7:0] cnt_q   [3];
  logic [7:0] cnt_d   [3];
  logic [2:0] press_ev;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      press_ev[i] = 1'b0;
      unique case (state_q[i])
        StReleased: begin
          if (btn_s[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = 8'd1;
          end
        end
        StPressWait: begin
          if (!btn_s[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = 8'd0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i]  = StHeld;
            cnt_d[i]    = 8'd0;
            press_ev[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        StHeld: begin
          if (!btn_s[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = 8'd1;
          end
        end
        StReleaseWait: begin
          if (btn_s[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = 8'd0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StReleased;
            cnt_d[i]   = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  logic rep_ev;

`ifdef BTN_COND_AUTO_REPEAT_EN
  localparam logic [7:0] RepLast = 8'(REPEAT_CYCLES - 1);

  logic [7:0] rep_q, rep_d;

  // Timer runs only while load stays in HELD; any exit or entry restarts it from zero.
  always_comb begin
    rep_d  = 8'd0;
    rep_ev = 1'b0;
    if (state_q[0] == StHeld && state_d[0] == StHeld) begin
      if (rep_q == RepLast) begin
        rep_ev = 1'b1;
      end else begin
        rep_d = rep_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^8'(REPEAT_CYCLES);
  assign rep_ev = 1'b0;
`endif

  logic       load_d, pre_d, clr_d;
  logic       load_q, pre_q, clr_q;
  logic [3:0] data_d, data_q;

  // Priority clr > pre > load; losing events are simply dropped.
  always_comb begin
    clr_d  = press_ev[2];
    pre_d  = press_ev[1] & ~press_ev[2];
    load_d = (press_ev[0] | rep_ev) & ~press_ev[1] & ~press_ev[2];
    data_d = load_d ? sw_s : data_q;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      load_q <= 1'b0;
      pre_q  <= 1'b0;
      clr_q  <= 1'b0;
      data_q <= 4'h0;
    end else begin
      load_q <= load_d;
      pre_q  <= pre_d;
      clr_q  <= clr_d;
      data_q <= data_d;
    end
  end

  assign cmd.load_pulse = load_q;
  assign cmd.pre_pulse  = pre_q;
  assign cmd.clr_pulse  = clr_q;
  assign cmd.data_out   = data_q;

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond: stimulus queues expected pulses, a negedge monitor checks them.
module tb_btn_cond;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       btn_load = 1'b0;
  logic       btn_pre = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] sw = 4'h0;

  btn_cond_if cmd ();

  btn_cond #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (16)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .btn_load (btn_load),
    .btn_pre  (btn_pre),
    .btn_clr  (btn_clr),
    .sw       (sw),
    .cmd      (cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = load, 1 = preset, 2 = clear
  typedef struct {
    int kind;
    int data;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_load"}, int'(cmd.load_pulse), 0);
    check({tag, "_pre"}, int'(cmd.pre_pulse), 0);
    check({tag, "_clr"}, int'(cmd.clr_pulse), 0);
    check({tag, "_data"}, int'(cmd.data_out), 0);
  endtask

  // Monitor: every sampled pulse must match the head of the expected queue.
  always @(negedge clk) begin
    int   n;
    int   kind;
    exp_t e;
    n = int'(cmd.load_pulse) + int'(cmd.pre_pulse) + int'(cmd.clr_pulse);
    if (n > 0) begin
      check("exclusive", n, 1);
      kind = cmd.clr_pulse ? 2 : (cmd.pre_pulse ? 1 : 0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", n, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_data", int'(cmd.data_out), e.data);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 clear = 1'b0;
    #1 check_quiet("reset");
    tick(3);
    clear = 1'b1;
    tick(3);

    // Clean load press, then long hold.
    sw = 4'h5;
    btn_load = 1'b1;
    push_exp(0, 5, cyc + 6);
`ifdef BTN_COND_AUTO_REPEAT_EN
    push_exp(0, 5, cyc + 22);
    push_exp(0, 5, cyc + 38);
    push_exp(0, 5, cyc + 54);
`endif
    tick(56);
    btn_load = 1'b0;
    tick(12);

    // Bouncing preset: 1,1,0,0 pattern for 12 cycles, then steady high.
    for (int k = 0; k < 12; k++) begin
      btn_pre = ((k / 2) % 2) == 0;
      tick(1);
    end
    btn_pre = 1'b1;
    push_exp(1, 5, cyc + 6);
    tick(20);
    btn_pre = 1'b0;
    tick(12);

    // Clear and load together: only clear pulses, data untouched.
    btn_clr  = 1'b1;
    btn_load = 1'b1;
    push_exp(2, 5, cyc + 6);
    tick(12);
    btn_load = 1'b0;
    tick(12);
    sw = 4'hA;
    btn_load = 1'b1;
    push_exp(0, 10, cyc + 6);
    tick(12);
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    tick(12);

    // Short dip while held is ignored; a long release re-arms.
    sw = 4'h3;
    btn_load = 1'b1;
    push_exp(0, 3, cyc + 6);
    tick(16);
    btn_load = 1'b0;
    tick(2);
    btn_load = 1'b1;
    tick(12);
    btn_load = 1'b0;
    sw = 4'h9;
    tick(10);
    btn_load = 1'b1;
    push_exp(0, 9, cyc + 6);
    tick(10);
    btn_load = 1'b0;
    tick(12);

    // Reset in the middle of a preset debounce; button stays held through release.
    btn_pre = 1'b1;
    tick(3);
    #1 clear = 1'b0;
    #1 check_quiet("async_reset");
    tick(2);
    clear = 1'b1;
    push_exp(1, 0, cyc + 6);
    tick(12);
    btn_pre = 1'b0;
    tick(12);

    check("pending_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_cond.md
# btn_cond

Button-conditioning front end that sits directly upstream of the 4-bit loadable counter. Synchronises and debounces three raw push-buttons (load, preset, clear), turns each debounced press into a single-cycle pulse and registers a 4-bit switch value, driving the counter's `en`, `pre`, `clear` and `data_in` inputs. Guarantees one counter command per physical press, with load data stable in the cycle `en` pulses.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a level change; legal 2..255.
- `REPEAT_CYCLES`, 16: auto-repeat period in cycles (used only with `BTN_COND_AUTO_REPEAT_EN`); legal 2..255.
- `clk`  in  1  single clock; all state on rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `btn_load`  in  1  raw load button, active-high, asynchronous, bouncy.
- `btn_pre`  in  1  raw preset button, same properties.
- `btn_clr`  in  1  raw clear button, same properties.
- `sw`  in  4  raw switch value, asynchronous.
- `load_pulse`  out  1  one-cycle load command (drives counter `en`).
- `pre_pulse`  out  1  one-cycle preset command.
- `clr_pulse`  out  1  one-cycle clear command.
- `data_out`  out  4  registered load value (drives counter `data_in`).

## Operation
- Each button and each `sw` bit passes a 2-flop synchroniser (reset 0). Filtering acts on the second-stage value `s`.
- Per-button FSM, states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT; 8-bit counter `cnt`:
  - RELEASED: `s`=1 -> PRESS_WAIT, `cnt`=1.
  - PRESS_WAIT: `s`=0 -> RELEASED, `cnt`=0; `s`=1 and `cnt`=DEBOUNCE_CYCLES-1 -> HELD, `cnt`=0, raise press event; else `cnt`+1.
  - HELD: `s`=0 -> RELEASE_WAIT, `cnt`=1.
  - RELEASE_WAIT: `s`=1 -> HELD, `cnt`=0; `s`=0 and `cnt`=DEBOUNCE_CYCLES-1 -> RELEASED, `cnt`=0; else `cnt`+1. No event on release.
- Press events become registered pulses at the same edge the FSM enters HELD; high exactly one cycle.
- Arbitration when events coincide on one edge: clr > pre > load. Only the winner pulses; losers are dropped (not deferred) but their FSMs still enter HELD. Outputs are mutually exclusive.
- `data_out` loads the synchronised `sw` on the same edge `load_pulse` rises; otherwise holds. Never changes on a pre/clr pulse.
- Reset (`clear`=0): all FSMs RELEASED, counters 0, synchronisers 0, all pulses 0, `data_out`=4'h0, immediately and asynchronously. Button held through reset release is treated as a new press with full latency.

## Timing
- Press latency: raw input rises and stays high before edge E0 -> pulse high after edge E(DEBOUNCE_CYCLES+1), low after the next edge. DEBOUNCE_CYCLES=4: pulse in the cycle after the 6th edge.
- Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored; a dip inside HELD shorter than DEBOUNCE_CYCLES does not re-arm.
- Minimum press-to-press spacing producing two pulses: 2*DEBOUNCE_CYCLES cycles low/high.
- `data_out` valid from the same edge as `load_pulse`; stable until the next load pulse.

## Configuration
- `BTN_COND_AUTO_REPEAT_EN` defined: load channel only, while in HELD, emits additional `load_pulse` (reloading `data_out` each time) every REPEAT_CYCLES cycles after the initial pulse; timer resets on leaving HELD; repeats obey arbitration (dropped if pre/clr event same edge).
- Undefined: exactly one `load_pulse` per press; repeat timer and `REPEAT_CYCLES` unused.

## Test plan
- Reset: drive `clear`=0 mid-PRESS_WAIT -> all outputs 0, `data_out`=0 immediately; release with `btn_pre` held -> `pre_pulse` after 6th edge post-release.
- Clean press, DEBOUNCE_CYCLES=4, `sw`=4'h5: `btn_load` 0->1 -> single `load_pulse` after 6th edge, `data_out`=4'h5 same cycle; held 50 cycles -> no further pulses (macro undefined).
- Bounce: `btn_pre` toggles 1/0 every 2 cycles for 12 cycles then stays 1 -> exactly one `pre_pulse`; zero pulses during bouncing.
- Simultaneous: `btn_clr` and `btn_load` rise same cycle -> only `clr_pulse`; `data_out` unchanged; later release/re-press of load -> `load_pulse`.
- Release dip: while HELD, `btn_load` low 2 cycles -> no new pulse; low 10 cycles then high -> one new pulse.
- With `BTN_COND_AUTO_REPEAT_EN`, REPEAT_CYCLES=16, `btn_load` held 60 cycles after first pulse -> 3 further pulses 16 cycles apart, each latching current `sw`.
